// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator: decodes the RV32I/RV64I immediate formats
// and hands the result downstream through a registered 2-entry skid buffer.
module imm_extend_pipe #(
  parameter int DPW  = 32,
  parameter int TAGW = 32
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:7]     instr_in,
  input  logic [2:0]      immsrc_in,
  input  logic [TAGW-1:0] tag_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DPW-1:0]  immext_out,
  output logic [TAGW-1:0] tag_out,
  output logic            illegal_out
);

  // Handshake: an input transfers on a rising edge where in_valid & in_ready;
  // an output transfers on a rising edge where out_valid & out_ready. While
  // out_valid & !out_ready the output entry is held unchanged, and in_ready is
  // a registered signal with no combinational dependence on out_ready.

  logic            s;
  logic [31:0]     imm32;
  logic [5:0]      shamt;
  logic [DPW-1:0]  dec_imm;
  logic            dec_ill;

  always_comb begin
    s       = instr_in[31];
    imm32   = '0;
    dec_ill = 1'b0;
    shamt   = (DPW == 64) ? instr_in[25:20] : {1'b0, instr_in[24:20]};
    case (immsrc_in)
      3'b000:  imm32 = {{20{s}}, instr_in[31:20]};
      3'b001:  imm32 = {{20{s}}, instr_in[31:25], instr_in[11:7]};
      3'b010:  imm32 = {{20{s}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
      3'b011:  imm32 = {instr_in[31:12], 12'h000};
      3'b100:  imm32 = {{12{s}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
      3'b101:  imm32 = {26'd0, shamt};
      default: dec_ill = 1'b1;
    endcase
  end

  // Every format is sign-extended from bit 31; shift amounts have bit 31 clear.
  generate
    if (DPW == 64) begin : g_ext64
      assign dec_imm = {{32{imm32[31]}}, imm32};
    end else begin : g_ext32
      assign dec_imm = imm32;
    end
  endgenerate

  logic            o_valid, k_valid;
  logic [DPW-1:0]  o_imm, k_imm;
  logic [TAGW-1:0] o_tag, k_tag;
  logic            o_ill, k_ill;
  logic            accept, o_free;

  assign accept = in_valid & in_ready;
  assign o_free = ~o_valid | out_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_valid <= 1'b0;
      o_imm   <= '0;
      o_tag   <= '0;
      o_ill   <= 1'b0;
      k_valid <= 1'b0;
      k_imm   <= '0;
      k_tag   <= '0;
      k_ill   <= 1'b0;
    end else if (flush) begin
      o_valid <= 1'b0;
      k_valid <= 1'b0;
    end else if (o_free) begin
      if (k_valid) begin
        // Skid entry is older than anything arriving now, so it goes first.
        o_valid <= 1'b1;
        o_imm   <= k_imm;
        o_tag   <= k_tag;
        o_ill   <= k_ill;
        k_valid <= accept;
        if (accept) begin
          k_imm <= dec_imm;
          k_tag <= tag_in;
          k_ill <= dec_ill;
        end
      end else begin
        o_valid <= accept;
        if (accept) begin
          o_imm <= dec_imm;
          o_tag <= tag_in;
          o_ill <= dec_ill;
        end
      end
    end else if (accept) begin
      k_valid <= 1'b1;
      k_imm   <= dec_imm;
      k_tag   <= tag_in;
      k_ill   <= dec_ill;
    end
  end

  assign in_ready    = ~k_valid;
  assign out_valid   = o_valid;
  assign immext_out  = o_imm;
  assign tag_out     = o_tag;
  assign illegal_out = o_ill;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: 32- and 64-bit builds driven in lockstep, checked
// against an arithmetic immediate model and a FIFO scoreboard.
module tb_imm_extend_pipe;

  localparam int TAGW = 32;

  typedef struct packed {
    logic [31:0]     imm32;
    logic [63:0]     imm64;
    logic [TAGW-1:0] tag;
    logic            ill;
  } ent_t;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0, arst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]     instr = '0;
  logic [2:0]      src = '0;
  logic [TAGW-1:0] tag = '0;

  logic            in_ready, out_valid, illegal_out;
  logic [31:0]     immext_out;
  logic [TAGW-1:0] tag_out;
  logic            in_ready64, out_valid64, illegal_out64;
  logic [63:0]     immext_out64;
  logic [TAGW-1:0] tag_out64;

  always #5 clk = ~clk;

  imm_extend_pipe #(.DPW(32), .TAGW(TAGW)) dut (
    .clk(clk), .arst_n(arst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr[31:7]), .immsrc_in(src), .tag_in(tag), .out_valid(out_valid),
    .out_ready(out_ready), .immext_out(immext_out), .tag_out(tag_out), .illegal_out(illegal_out)
  );

  imm_extend_pipe #(.DPW(64), .TAGW(TAGW)) dut64 (
    .clk(clk), .arst_n(arst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr_in(instr[31:7]), .immsrc_in(src), .tag_in(tag), .out_valid(out_valid64),
    .out_ready(out_ready), .immext_out(immext_out64), .tag_out(tag_out64),
    .illegal_out(illegal_out64)
  );

  // ---------------- checking ----------------
  ent_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic longint sx(input longint x, input int bits);
    if (x >= (longint'(1) << (bits - 1))) return x - (longint'(1) << bits);
    return x;
  endfunction

  // Reference model: rebuild each immediate's numeric value from its fields.
  function automatic ent_t model(input logic [31:0] ins, input logic [2:0] s, input logic [TAGW-1:0] t);
    ent_t   e;
    longint u, v;
    u     = longint'({32'd0, ins});
    v     = 0;
    e.ill = 1'b0;
    e.tag = t;
    case (s)
      3'd0: v = sx(u >> 20, 12);
      3'd1: v = sx(((u >> 25) << 5) + ((u >> 7) & 31), 12);
      3'd2: v = sx((((u >> 31) & 1) << 12) + (((u >> 7) & 1) << 11)
                   + (((u >> 25) & 63) << 5) + (((u >> 8) & 15) << 1), 13);
      3'd3: v = sx(u & 64'hFFFF_F000, 32);
      3'd4: v = sx((((u >> 31) & 1) << 20) + (((u >> 12) & 255) << 12)
                   + (((u >> 20) & 1) << 11) + (((u >> 21) & 1023) << 1), 21);
      3'd5: v = 0;
      default: e.ill = 1'b1;
    endcase
    e.imm32 = v[31:0];
    e.imm64 = v;
    if (s == 3'd5) begin
      e.imm32 = 32'((u >> 20) & 31);
      e.imm64 = (u >> 20) & 63;
    end
    return e;
  endfunction

  // Scoreboard: looks at the signals the upcoming rising edge will act on.
  logic            hold_prev = 1'b0;
  logic [31:0]     hold_imm;
  logic [63:0]     hold_imm64;
  logic [TAGW-1:0] hold_tag;
  logic            hold_ill;

  always @(negedge clk) begin
    ent_t e;
    if (!arst_n) begin
      hold_prev = 1'b0;
    end else begin
      check("out_valid", out_valid, exp_q.size() > 0);
      check("out_valid64", out_valid64, exp_q.size() > 0);
      check("in_ready", in_ready, exp_q.size() < 2);
      check("in_ready64", in_ready64, exp_q.size() < 2);
      if (hold_prev) begin
        check("hold_imm", immext_out, hold_imm);
        check("hold_imm64", immext_out64, hold_imm64);
        check("hold_tag", tag_out, hold_tag);
        check("hold_ill", illegal_out, hold_ill);
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("imm", immext_out, e.imm32);
        check("imm64", immext_out64, e.imm64);
        check("tag", tag_out, e.tag);
        check("tag64", tag_out64, e.tag);
        check("illegal", illegal_out, e.ill);
        check("illegal64", illegal_out64, e.ill);
      end
      hold_prev  = out_valid && !out_ready && !flush;
      hold_imm   = immext_out;
      hold_imm64 = immext_out64;
      hold_tag   = tag_out;
      hold_ill   = illegal_out;
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(instr, src, tag));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] i, input logic [2:0] s, input logic [TAGW-1:0] t);
    in_valid = 1'b1;
    instr    = i;
    src      = s;
    tag      = t;
  endtask

  task automatic wait_accept();
    logic r;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      r = in_ready;
      cycle();
      if (r) return;
    end
    n_checks++;
    $error("FAIL accept_timeout: got in_ready=0 for 100 cycles expected acceptance");
  endtask

  task automatic drive(input logic [31:0] i, input logic [2:0] s, input logic [TAGW-1:0] t);
    present(i, s, t);
    wait_accept();
  endtask

  task automatic reset_mid();
    #1;
    arst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_imm", immext_out, 32'd0);
    check("rst_imm64", immext_out64, 64'd0);
    check("rst_tag", tag_out, 32'd0);
    check("rst_illegal", illegal_out, 1'b0);
    exp_q.delete();
    in_valid = 1'b0;
    cycle();
    arst_n = 1'b1;
    cycle();
    check("post_rst_in_ready", in_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   pct;
    logic acc;

    #3;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_imm", immext_out, 32'd0);
    check("reset_imm64", immext_out64, 64'd0);
    check("reset_tag", tag_out, 32'd0);
    check("reset_illegal", illegal_out, 1'b0);
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    cycle();
    check("ready_after_reset", in_ready, 1'b1);

    // single addi x1,x0,-1
    out_ready = 1'b1;
    drive(32'hFFF0_0093, 3'd0, 32'h100);
    check("t1_valid", out_valid, 1'b1);
    check("t1_imm", immext_out, 32'hFFFF_FFFF);
    check("t1_imm64", immext_out64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t1_tag", tag_out, 32'h100);
    check("t1_illegal", illegal_out, 1'b0);

    // back-to-back format sweep
    drive(32'hFE11_2E23, 3'd1, 32'h101);
    check("sweep_s", immext_out, 32'hFFFF_FFFC);
    drive(32'hFE00_0CE3, 3'd2, 32'h102);
    check("sweep_b", immext_out, 32'hFFFF_FFF8);
    drive(32'h1234_50B7, 3'd3, 32'h103);
    check("sweep_u", immext_out, 32'h1234_5000);
    drive(32'h0010_006F, 3'd4, 32'h104);
    check("sweep_j", immext_out, 32'h0000_0800);
    drive(32'h4050_D093, 3'd5, 32'h105);
    check("sweep_shamt", immext_out, 32'h0000_0005);
    drive(32'hFFFF_FFFF, 3'd7, 32'h106);
    check("sweep_ill_imm", immext_out, 32'd0);
    check("sweep_ill_flag", illegal_out, 1'b1);
    drive(32'h8000_00B7, 3'd3, 32'h107);
    check("rv64_u", immext_out64, 64'hFFFF_FFFF_8000_0000);
    check("rv32_u", immext_out, 32'h8000_0000);
    drive(32'h03F0_9093, 3'd5, 32'h108);
    check("rv64_shamt", immext_out64, 64'h0000_0000_0000_003F);
    check("rv32_shamt", immext_out, 32'h0000_001F);
    in_valid = 1'b0;
    repeat (2) cycle();

    // backpressure: A in O, B in K, C held
    out_ready = 1'b0;
    drive(32'h0010_0093, 3'd0, 32'h300);
    drive(32'h0020_0093, 3'd0, 32'h301);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_tag_a", tag_out, 32'h300);
    present(32'h0030_0093, 3'd0, 32'h302);
    repeat (3) cycle();
    check("bp_in_ready_held", in_ready, 1'b0);
    check("bp_imm_a", immext_out, 32'h1);
    out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    repeat (3) cycle();
    check("bp_ready_back", in_ready, 1'b1);

    // flush with both entries held, then flush with an accept on the same edge
    out_ready = 1'b0;
    drive(32'h0040_0093, 3'd0, 32'h400);
    drive(32'h0050_0093, 3'd0, 32'h401);
    in_valid = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    drive(32'h0060_0093, 3'd0, 32'h402);
    present(32'h0070_0093, 3'd0, 32'h403);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush2_out_valid", out_valid, 1'b0);
    check("flush2_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (4) cycle();
    check("flush_nothing_out", out_valid, 1'b0);

    // asynchronous reset between edges with an entry on the output
    out_ready = 1'b0;
    drive(32'h0000_0000, 3'd6, 32'h500);
    check("pre_rst_illegal", illegal_out, 1'b1);
    reset_mid();
    drive(32'hFFF0_0093, 3'd0, 32'h501);
    check("pre_rst_imm", immext_out, 32'hFFFF_FFFF);
    reset_mid();

    // randomized traffic with varying backpressure and occasional flush
    acc = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      case (i / 150)
        0:       pct = 80;
        1:       pct = 25;
        2:       pct = 100;
        default: pct = 50;
      endcase
      if (!in_valid || acc) begin
        if ($urandom_range(0, 3) != 0)
          present($urandom, 3'($urandom_range(0, 7)), $urandom);
        else
          in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 99) < pct);
      flush     = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      cycle();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) cycle();
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
